// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF core: FSM encoding, width
// helper and the per-channel half-period function.
package ro_puf_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARM     = 3'd1;
   localparam logic [2:0] ST_MEASURE = 3'd2;
   localparam logic [2:0] ST_COMPARE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      ARM     = ST_ARM,
      MEASURE = ST_MEASURE,
      COMPARE = ST_COMPARE,
      DONE    = ST_DONE
   } state_t;

   // Bits needed to index n items; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int half_period(input int idx, input int base, input int step);
      return base + idx * step;
   endfunction

endpackage

// File: rtl/ro_channel.sv
// One emulated oscillator channel: toggles every HALF enabled cycles and
// strobes rise in the cycle whose edge drives its output from 0 to 1.
module ro_channel
   import ro_puf_pkg::*;
#(
   parameter int HALF = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic rise
);

   localparam int PH_W = clog2(HALF);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

   logic [PH_W-1:0] phase_r;
   logic            osc_r;
   logic            wrap_s;

   assign wrap_s = (phase_r == PH_LAST);
   // Strobe is combinational so an edge in the final measured cycle is still counted.
   assign rise   = en & ~clr & wrap_s & ~osc_r;

   // Phase counter and toggle register, held at zero unless enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_r <= '0;
         osc_r   <= 1'b0;
      end else if (clr || !en) begin
         phase_r <= '0;
         osc_r   <= 1'b0;
      end else if (wrap_s) begin
         phase_r <= '0;
         osc_r   <= ~osc_r;
      end else begin
         phase_r <= phase_r + PH_W'(1);
         osc_r   <= osc_r;
      end
   end

endmodule

// File: rtl/ro_puf_core.sv
// Ring-oscillator PUF measurement core: runs a challenge-selected channel pair
// for a fixed window, counts rising edges and compares the counts.
module ro_puf_core
   import ro_puf_pkg::*;
#(
   parameter  int NUM_RO   = 16,
   parameter  int DIV_BASE = 10,
   parameter  int DIV_STEP = 1,
   parameter  int WINDOW   = 1024,
   parameter  int CNT_W    = 16,
   localparam int IDX_W    = clog2(NUM_RO)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] chal_a,
   input  logic [IDX_W-1:0] chal_b,
   output logic             busy,
   output logic             done,
   output logic             resp,
   output logic             tie,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   localparam int               WIN_W    = clog2(WINDOW);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W + 1)'(NUM_RO);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_RO - 1);

   state_t             state_r;
   logic [IDX_W-1:0]   sel_a_r, sel_b_r;
   logic [WIN_W-1:0]   win_r;
   logic [CNT_W-1:0]   acc_a_r, acc_b_r;
   logic [NUM_RO-1:0]  rise_s;
   logic               en_s, clr_s;
   logic               hit_a_s, hit_b_s;

   function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] idx);
      if ({1'b0, idx} >= IDX_LIM) begin
         return IDX_MAX;
      end else begin
         return idx;
      end
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
      if (hit && (v != CNT_MAX)) begin
         return v + CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

   assign en_s    = (state_r == MEASURE);
   assign clr_s   = (state_r == ARM);
   assign hit_a_s = rise_s[sel_a_r];
   assign hit_b_s = rise_s[sel_b_r];

   for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
      ro_channel #(
         .HALF (half_period(i, DIV_BASE, DIV_STEP))
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .en   (en_s),
         .clr  (clr_s),
         .rise (rise_s[i])
      );
   end

   // Measurement FSM with window counter, edge accumulators and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         sel_a_r <= '0;
         sel_b_r <= '0;
         win_r   <= '0;
         acc_a_r <= '0;
         acc_b_r <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         resp    <= 1'b0;
         tie     <= 1'b0;
         cnt_a   <= '0;
         cnt_b   <= '0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sel_a_r <= clamp_idx(chal_a);
                  sel_b_r <= clamp_idx(chal_b);
                  acc_a_r <= '0;
                  acc_b_r <= '0;
                  busy    <= 1'b1;
                  state_r <= ARM;
               end else begin
                  state_r <= IDLE;
               end
            end
            ARM: begin
               win_r   <= '0;
               state_r <= MEASURE;
            end
            MEASURE: begin
               acc_a_r <= sat_inc(acc_a_r, hit_a_s);
               acc_b_r <= sat_inc(acc_b_r, hit_b_s);
               if (win_r == WIN_LAST) begin
                  state_r <= COMPARE;
               end else begin
                  win_r <= win_r + WIN_W'(1);
               end
            end
            COMPARE: begin
               cnt_a   <= acc_a_r;
               cnt_b   <= acc_b_r;
               resp    <= (acc_a_r > acc_b_r);
               tie     <= (acc_a_r == acc_b_r);
               busy    <= 1'b0;
               done    <= 1'b1;
               state_r <= DONE;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ro_puf_core.sv
// Directed bench for ro_puf_core: latency, counts, tie, ignored start,
// mid-run reset, back-to-back runs and counter saturation.
module tb_ro_puf_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  chal_a, chal_b;
   logic        busy, done, resp, tie;
   logic [15:0] cnt_a, cnt_b;

   logic        s_start;
   logic [3:0]  s_chal_a, s_chal_b;
   logic        s_busy, s_done, s_resp, s_tie;
   logic [3:0]  s_cnt_a, s_cnt_b;

   int tests = 0;
   int fails = 0;
   int cyc;
   int dcount;
   int bcount;

   always #5 clk = ~clk;

   ro_puf_core #(
      .NUM_RO(16), .DIV_BASE(10), .DIV_STEP(1), .WINDOW(1024), .CNT_W(16)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .chal_a(chal_a), .chal_b(chal_b),
      .busy(busy), .done(done), .resp(resp), .tie(tie), .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   ro_puf_core #(
      .NUM_RO(16), .DIV_BASE(1), .DIV_STEP(1), .WINDOW(1024), .CNT_W(4)
   ) u_sat (
      .clk(clk), .rst(rst), .start(s_start), .chal_a(s_chal_a), .chal_b(s_chal_b),
      .busy(s_busy), .done(s_done), .resp(s_resp), .tie(s_tie), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Called at a negedge: the next posedge samples start (edge 0).
   task automatic kick(input logic [3:0] a, input logic [3:0] b);
      chal_a = a;
      chal_b = b;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Returns the cycle number (ARM = cycle 1) in which done is seen, or -1.
   task automatic wait_done(input logic use_sat, output int c);
      c = -1;
      for (int n = 1; n <= 3000; n++) begin
         @(posedge clk);
         @(negedge clk);
         if ((use_sat ? s_done : done) === 1'b1) begin
            c = n + 1;
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; chal_a = 4'd0; chal_b = 4'd0;
      s_start = 1'b0; s_chal_a = 4'd0; s_chal_b = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state and idle behaviour
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) dcount = dcount + 1;
      end
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_resp", 32'(resp), 32'd0);
      check("rst_tie", 32'(tie), 32'd0);
      check("rst_cnt_a", 32'(cnt_a), 32'd0);
      check("rst_cnt_b", 32'(cnt_b), 32'd0);
      check("idle_no_done", 32'(dcount), 32'd0);

      // chal 0 (H=10) vs 15 (H=25)
      kick(4'd0, 4'd15);
      check("busy_arm", 32'(busy), 32'd1);
      wait_done(1'b0, cyc);
      check("lat_0_15", 32'(cyc), 32'd1027);
      check("busy_at_done", 32'(busy), 32'd0);
      check("cnt_a_0_15", 32'(cnt_a), 32'd51);
      check("cnt_b_0_15", 32'(cnt_b), 32'd20);
      check("resp_0_15", 32'(resp), 32'd1);
      check("tie_0_15", 32'(tie), 32'd0);

      // Back-to-back: start held in DONE, swapped challenge
      kick(4'd15, 4'd0);
      check("done_pulse_1cyc", 32'(done), 32'd0);
      check("busy_b2b", 32'(busy), 32'd1);
      wait_done(1'b0, cyc);
      check("period_b2b", 32'(cyc), 32'd1027);
      check("cnt_a_15_0", 32'(cnt_a), 32'd20);
      check("cnt_b_15_0", 32'(cnt_b), 32'd51);
      check("resp_15_0", 32'(resp), 32'd0);
      check("tie_15_0", 32'(tie), 32'd0);

      // Same channel on both sides
      @(negedge clk);
      kick(4'd5, 4'd5);
      wait_done(1'b0, cyc);
      check("cnt_a_5_5", 32'(cnt_a), 32'd34);
      check("cnt_b_5_5", 32'(cnt_b), 32'd34);
      check("resp_5_5", 32'(resp), 32'd0);
      check("tie_5_5", 32'(tie), 32'd1);

      // Start during MEASURE with another challenge must be ignored
      @(negedge clk);
      kick(4'd0, 4'd15);
      repeat (98) @(negedge clk);
      chal_a = 4'd3; chal_b = 4'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b0, cyc);
      check("ign_cnt_a", 32'(cnt_a), 32'd51);
      check("ign_cnt_b", 32'(cnt_b), 32'd20);
      check("ign_resp", 32'(resp), 32'd1);

      // Mid-run reset clears everything at once and suppresses done
      @(negedge clk);
      kick(4'd0, 4'd15);
      repeat (499) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_cnt_a", 32'(cnt_a), 32'd0);
      check("mid_rst_cnt_b", 32'(cnt_b), 32'd0);
      check("mid_rst_resp", 32'(resp), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      bcount = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (done === 1'b1) dcount = dcount + 1;
         if (busy === 1'b1) bcount = bcount + 1;
      end
      check("post_rst_no_done", 32'(dcount), 32'd0);
      check("post_rst_no_busy", 32'(bcount), 32'd0);

      // Fresh start after reset: chal 3 (H=13) vs 4 (H=14)
      kick(4'd3, 4'd4);
      wait_done(1'b0, cyc);
      check("lat_3_4", 32'(cyc), 32'd1027);
      check("cnt_a_3_4", 32'(cnt_a), 32'd39);
      check("cnt_b_3_4", 32'(cnt_b), 32'd37);
      check("resp_3_4", 32'(resp), 32'd1);
      check("tie_3_4", 32'(tie), 32'd0);

      // Saturation: 4-bit counters, H=1 and H=2
      @(negedge clk);
      s_chal_a = 4'd0; s_chal_b = 4'd1; s_start = 1'b1;
      @(posedge clk);
      #1;
      s_start = 1'b0;
      wait_done(1'b1, cyc);
      check("sat_lat", 32'(cyc), 32'd1027);
      check("sat_cnt_a", 32'(s_cnt_a), 32'd15);
      check("sat_cnt_b", 32'(s_cnt_b), 32'd15);
      check("sat_resp", 32'(s_resp), 32'd0);
      check("sat_tie", 32'(s_tie), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ro_puf_core.md
# ro_puf_core

Parametrised ring-oscillator PUF measurement core. It holds NUM_RO clock-derived oscillator channels, each with a distinct half-period. On a start request it runs a challenge-selected pair for a fixed window and counts rising edges on both. It compares the two counts to produce one response bit. It sits between the challenge source (bus/UART controller) and the response collector, and replaces the single fixed ring oscillator with a selectable, measurable array.

## Interface
Parameters:
- NUM_RO, 16: oscillator channels; IDX_W = $clog2(NUM_RO)
- DIV_BASE, 10: half-period of channel 0, in clk cycles (≥1)
- DIV_STEP, 1: half-period increment per channel; channel i half-period H(i) = DIV_BASE + i*DIV_STEP
- WINDOW, 1024: measurement length in clk cycles (≥2)
- CNT_W, 16: edge-counter width

Ports (clk is the clock; rst is asynchronous, active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request a measurement; sampled only in IDLE or DONE
- chal_a  in  IDX_W  first oscillator index; sampled with start
- chal_b  in  IDX_W  second oscillator index; sampled with start
- busy  out  1  high from ARM through COMPARE
- done  out  1  one-cycle pulse; results valid from this cycle
- resp  out  1  response bit, 1 iff cnt_a > cnt_b
- tie  out  1  cnt_a == cnt_b
- cnt_a  out  CNT_W  rising-edge count of channel chal_a
- cnt_b  out  CNT_W  rising-edge count of channel chal_b

## Operation
- FSM states: IDLE, ARM, MEASURE, COMPARE, DONE.
  - IDLE/DONE + start → ARM: latch chal_a/chal_b and clear both counters.
  - ARM → MEASURE: clear all oscillator phases and phase counters, so every output is 0.
  - MEASURE lasts exactly WINDOW cycles, then → COMPARE.
  - COMPARE → DONE: register resp, tie, cnt_a and cnt_b.
  - DONE → IDLE after 1 cycle, unless start is high, in which case → ARM.
- Oscillators are enabled only in MEASURE. Otherwise they are held at output 0 with counters cleared (the NAND enable equivalent).
- Each enabled channel toggles its output every H(i) cycles. A rising edge is a 0→1 change of its registered output. Edge detection is synchronous in clk; there are no derived clocks.
- Edge counters increment on each rising edge of the selected channel. They saturate at 2^CNT_W−1 and never wrap.
- Expected count per window: floor((WINDOW + H) / (2H)).
- Comparison is unsigned. When chal_a == chal_b, the counts are equal, so tie=1 and resp=0.
- start during ARM, MEASURE or COMPARE is ignored; the latched challenge is unchanged.
- resp, tie, cnt_a and cnt_b hold their values until the next COMPARE.
- Out-of-range indices (≥ NUM_RO) are clamped to NUM_RO−1.

## Timing
- Reset values: busy=0, done=0, resp=0, tie=0, cnt_a=0, cnt_b=0; FSM=IDLE; all oscillator outputs 0.
- Latency: start is sampled at edge 0. ARM occupies cycle 1, MEASURE occupies cycles 2..WINDOW+1, COMPARE occupies cycle WINDOW+2, and done is high in cycle WINDOW+3.
- busy rises the cycle after start is sampled. It falls in the same cycle done rises.
- Back-to-back: start held high in DONE gives a done pulse every WINDOW+3 cycles.
- rst asserted mid-operation returns the block to reset values immediately. No done pulse is issued, and the next measurement needs a fresh start.
- In MEASURE, the counter update and the window-end decision happen in the same cycle. An edge occurring in the last MEASURE cycle is counted.

## Structure
- ro_puf_pkg holds:
  - the state encoding (IDLE..DONE) as localparams;
  - the clog2 helper for IDX_W;
  - the half-period function H(i).
- Sub-module ro_channel: phase counter, toggle register, enable/clear inputs, a rising-edge strobe output and a HALF parameter. It is instantiated NUM_RO times in a generate loop.
- ro_puf_core contains the FSM, the window counter, the two index muxes over the edge strobes, the saturating counters and the comparator.

## Test plan
Defaults unless noted (DIV_BASE=10, DIV_STEP=1, WINDOW=1024, CNT_W=16).
- rst, then idle 10 cycles → all outputs 0, busy=0, no done.
- start with chal_a=0 (H=10), chal_b=15 (H=25) → done at cycle 1027 after start; cnt_a=51, cnt_b=20, resp=1, tie=0.
- start with chal_a=15, chal_b=0 → cnt_a=20, cnt_b=51, resp=0, tie=0.
- chal_a=chal_b=5 (H=15) → cnt_a=cnt_b=34, resp=0, tie=1.
- start with chal 0/15, second start with chal 3/4 at cycle 100, rst pulse at cycle 500 → the second start is ignored. After rst all outputs are 0 and no done occurs. A new start then gives results for the new challenge.
- CNT_W=4, DIV_BASE=1, chal_a=0 (H=1), chal_b=1 (H=2) → both counts saturate at 15; resp=0, tie=1.
